// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS datapath: ALU control codes and the
// state encoding of the serial execute unit.
package mips_pkg;

    // Codes emitted by ALU control
    localparam logic [1:0] ALU_CTL_ADD = 2'b00;
    localparam logic [1:0] ALU_CTL_SUB = 2'b01;
    localparam logic [1:0] ALU_CTL_AND = 2'b10;
    localparam logic [1:0] ALU_CTL_OR  = 2'b11;

    // Serial execute unit states
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } exec_state_t;

    // True for the operations that use the carry chain and report overflow
    function automatic logic is_arith(input logic [1:0] ctl);
        return (ctl == ALU_CTL_ADD) || (ctl == ALU_CTL_SUB);
    endfunction

endpackage

// File: rtl/alu_slice.sv
// One SLICE-bit ALU step: add/sub/and/or with carry in, carry out and the
// carry into the slice MSB (used for signed overflow on the top slice).
module alu_slice
    import mips_pkg::*;
#(
    parameter int SLICE = 8
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic [1:0]       ctl,
    input  logic             cin,
    output logic [SLICE-1:0] y,
    output logic             cout,
    output logic             c_msb
);

    logic [SLICE-1:0] b_eff;
    logic [SLICE-1:0] sum_lo;   // SLICE-1 low sum bits plus carry into MSB
    logic [1:0]       sum_hi;   // MSB sum bit plus carry out

    // Split the adder at the MSB so the carry into the top bit is visible
    always_comb begin
        b_eff  = (ctl == ALU_CTL_SUB) ? ~b : b;
        sum_lo = {1'b0, a[SLICE-2:0]} + {1'b0, b_eff[SLICE-2:0]} + {{(SLICE-1){1'b0}}, cin};
        sum_hi = {1'b0, a[SLICE-1]} + {1'b0, b_eff[SLICE-1]} + {1'b0, sum_lo[SLICE-1]};

        y     = '0;
        cout  = 1'b0;
        c_msb = 1'b0;
        case (ctl)
            ALU_CTL_ADD, ALU_CTL_SUB: begin
                y     = {sum_hi[0], sum_lo[SLICE-2:0]};
                cout  = sum_hi[1];
                c_msb = sum_lo[SLICE-1];
            end
            ALU_CTL_AND: y = a & b;
            ALU_CTL_OR:  y = a | b;
            default:     y = '0;
        endcase
    end

endmodule

// File: rtl/alu_serial_exec.sv
// Multi-cycle execute unit: latches operands on a valid/ready handshake,
// runs them through one shared alu_slice LSB-first, and holds the result,
// zero and overflow flags until downstream accepts them.
module alu_serial_exec
    import mips_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       ALU_ctl,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NSLICE - 1);

    exec_state_t                   state_q, state_d;
    logic [CNT_W-1:0]              cnt_q, cnt_d;
    logic                          carry_q, carry_d;
    logic [NSLICE-1:0][SLICE-1:0]  a_q, a_d;
    logic [NSLICE-1:0][SLICE-1:0]  b_q, b_d;
    logic [1:0]                    ctl_q, ctl_d;
    logic [NSLICE-1:0][SLICE-1:0]  res_q, res_d;
    logic                          zero_q, zero_d;
    logic                          ovf_q, ovf_d;

    logic [SLICE-1:0]              slice_y;
    logic                          slice_cin;
    logic                          slice_cout;
    logic                          slice_cmsb;

    // Shared slice datapath, fed with slice cnt_q of the latched operands
    alu_slice #(
        .SLICE (SLICE)
    ) u_slice (
        .a     (a_q[cnt_q]),
        .b     (b_q[cnt_q]),
        .ctl   (ctl_q),
        .cin   (slice_cin),
        .y     (slice_y),
        .cout  (slice_cout),
        .c_msb (slice_cmsb)
    );

    // First slice takes the subtract carry-in; later slices chain the carry flop
    always_comb begin
        slice_cin = (cnt_q == '0) ? (ctl_q == ALU_CTL_SUB) : carry_q;
    end

    // Next-state, counter, operand capture and result accumulation
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        ctl_d   = ctl_q;
        res_d   = res_q;
        zero_d  = zero_q;
        ovf_d   = ovf_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d     = src_a;
                    b_d     = src_b;
                    ctl_d   = ALU_ctl;
                    cnt_d   = '0;
                    carry_d = 1'b0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                res_d[cnt_q] = slice_y;
                carry_d      = slice_cout;
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_DONE;
                    // Flags come from the full result, including the slice just written
                    zero_d  = (res_d == '0);
                    ovf_d   = is_arith(ctl_q) ? (slice_cmsb ^ slice_cout) : 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control and visible output registers, cleared by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            res_q   <= '0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
        end
    end

    // Latched operands are only read in RUN, so they need no reset
    always_ff @(posedge clk) begin
        a_q   <= a_d;
        b_q   <= b_d;
        ctl_q <= ctl_d;
    end

    // Handshake outputs decode directly from the state register
    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        out_valid = (state_q == ST_DONE);
        result    = res_q;
        zero      = zero_q;
        overflow  = ovf_q;
    end

endmodule

// File: tb/tb_alu_serial_exec.sv
// Scoreboard bench for alu_serial_exec: expectations are queued when an
// operation is accepted and compared when the unit hands a result over.
module tb_alu_serial_exec;
    import mips_pkg::*;

    localparam int WIDTH  = 32;
    localparam int SLICE  = 8;
    localparam int NSLICE = WIDTH / SLICE;
    localparam int LAT    = NSLICE + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              out_ready;
    logic [1:0]        alu_ctl;
    logic [WIDTH-1:0]  src_a;
    logic [WIDTH-1:0]  src_b;
    logic              in_ready;
    logic              out_valid;
    logic [WIDTH-1:0]  result;
    logic              zero;
    logic              overflow;

    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic             z;
        logic             v;
    } exp_t;

    exp_t sb_q[$];
    exp_t e1;
    int   n_cmp   = 0;
    int   n_err   = 0;
    int   cyc     = 0;
    int   acc_cyc = 0;
    logic ov_prev = 1'b0;

    alu_serial_exec #(
        .WIDTH (WIDTH),
        .SLICE (SLICE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ALU_ctl   (alu_ctl),
        .src_a     (src_a),
        .src_b     (src_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [1:0] c, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] r;
        logic             v;
        v = 1'b0;
        case (c)
            ALU_CTL_ADD: begin
                r = a + b;
                v = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_CTL_SUB: begin
                r = a - b;
                v = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_CTL_AND: r = a & b;
            default:     r = a | b;
        endcase
        return '{res: r, z: (r == '0), v: v};
    endfunction

    // Wait for in_ready, present one operation for exactly one accepting edge,
    // then scramble the inputs so late changes would corrupt a bad latch
    task automatic send(input logic [1:0] c, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        for (int i = 0; i < 50; i++) begin
            if (in_ready) break;
            @(posedge clk); #1;
        end
        check_val("in_ready_wait", {31'b0, in_ready}, 32'd1);
        sb_q.push_back(model(c, a, b));
        alu_ctl  = c;
        src_a    = a;
        src_b    = b;
        in_valid = 1'b1;
        acc_cyc  = cyc;
        @(posedge clk); #1;
        in_valid = 1'b0;
        src_a    = $urandom;
        src_b    = $urandom;
        alu_ctl  = 2'($urandom_range(0, 3));
    endtask

    task automatic drain();
        for (int i = 0; i < 100; i++) begin
            if (sb_q.size() == 0) break;
            @(posedge clk); #1;
        end
        check_val("drain", sb_q.size(), 32'd0);
    endtask

    // Output monitor: latency of each new result and scoreboard comparison on handover
    always @(negedge clk) begin
        exp_t e;
        if (out_valid && !ov_prev) begin
            check_val("latency", cyc - acc_cyc, LAT);
        end
        if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                check_val("unexpected_out", sb_q.size(), 32'd1);
            end else begin
                e = sb_q.pop_front();
                check_val("result",   result, e.res);
                check_val("zero",     {31'b0, zero}, {31'b0, e.z});
                check_val("overflow", {31'b0, overflow}, {31'b0, e.v});
            end
        end
        ov_prev = out_valid;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        alu_ctl   = 2'b00;
        src_a     = '0;
        src_b     = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        check_val("rst_in_ready",  {31'b0, in_ready},  32'd1);
        check_val("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check_val("rst_result",    result,             32'd0);
        check_val("rst_zero",      {31'b0, zero},      32'd0);
        check_val("rst_overflow",  {31'b0, overflow},  32'd0);

        // Directed arithmetic and logic cases
        send(ALU_CTL_ADD, 32'h0000_0005, 32'h0000_0003);
        send(ALU_CTL_SUB, 32'h0000_0007, 32'h0000_0007);
        send(ALU_CTL_SUB, 32'h0000_0000, 32'h0000_0001);
        send(ALU_CTL_ADD, 32'h7FFF_FFFF, 32'h0000_0001);
        send(ALU_CTL_SUB, 32'h8000_0000, 32'h0000_0001);
        send(ALU_CTL_AND, 32'hF0F0_F0F0, 32'hFF00_FF00);
        send(ALU_CTL_OR,  32'hF0F0_F0F0, 32'hFF00_FF00);
        send(ALU_CTL_ADD, 32'hFFFF_FFFF, 32'h0000_0001);
        send(ALU_CTL_ADD, 32'h8000_0000, 32'h8000_0000);
        send(ALU_CTL_SUB, 32'h7FFF_FFFF, 32'hFFFF_FFFF);
        send(ALU_CTL_ADD, 32'h0000_00FF, 32'h0000_0001);
        for (int i = 0; i < 12; i++) begin
            send(2'($urandom_range(0, 3)), $urandom, $urandom);
        end
        drain();

        // Backpressure: hold the result for 10 cycles with a new op waiting
        out_ready = 1'b0;
        e1 = model(ALU_CTL_ADD, 32'h1234_5678, 32'h1111_1111);
        send(ALU_CTL_ADD, 32'h1234_5678, 32'h1111_1111);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        check_val("bp_valid_wait", {31'b0, out_valid}, 32'd1);
        alu_ctl  = ALU_CTL_SUB;
        src_a    = 32'h0000_0010;
        src_b    = 32'h0000_0020;
        in_valid = 1'b1;
        sb_q.push_back(model(ALU_CTL_SUB, 32'h0000_0010, 32'h0000_0020));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_val("bp_result",    result,              e1.res);
            check_val("bp_zero",      {31'b0, zero},       {31'b0, e1.z});
            check_val("bp_overflow",  {31'b0, overflow},   {31'b0, e1.v});
            check_val("bp_out_valid", {31'b0, out_valid},  32'd1);
            check_val("bp_in_ready",  {31'b0, in_ready},   32'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check_val("bp_release_in_ready",  {31'b0, in_ready},  32'd1);
        check_val("bp_release_out_valid", {31'b0, out_valid}, 32'd0);
        acc_cyc = cyc;
        @(posedge clk); #1;
        check_val("bp_accepted", {31'b0, in_ready}, 32'd0);
        in_valid = 1'b0;
        drain();

        // Reset in the middle of RUN discards the operation
        send(ALU_CTL_ADD, 32'h0000_0005, 32'h0000_0006);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb_q.delete();
        check_val("midrst_in_ready",  {31'b0, in_ready},  32'd1);
        check_val("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        check_val("midrst_result",    result,             32'd0);
        check_val("midrst_zero",      {31'b0, zero},      32'd0);
        repeat (8) @(posedge clk);
        #1;
        check_val("midrst_idle", {31'b0, out_valid}, 32'd0);
        send(ALU_CTL_ADD, 32'h0000_0001, 32'h0000_0001);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
